// File: rtl/adder_33.sv
// Two-stage pipelined unsigned adder with carry-out and a valid tag.
// The low half is added in stage 1 and its carry feeds the high half in stage 2.
module adder_33 #(
    parameter int WIDTH = 32,
    parameter int SPLIT = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             out_valid
);

    localparam int HI = WIDTH - SPLIT;

    // Stage 1: low-half sum and carry, high operands parked alongside
    logic [SPLIT:0]   lo_d;
    logic [SPLIT-1:0] lo_q;
    logic             c1_q;
    logic [HI-1:0]    a_hi_q;
    logic [HI-1:0]    b_hi_q;
    logic             v1_q;

    // Stage 2: final result
    logic [HI:0]      hi_d;
    logic [WIDTH-1:0] sum_q;
    logic             carry_q;
    logic             v2_q;

    always_comb begin
        lo_d = {1'b0, A[SPLIT-1:0]} + {1'b0, B[SPLIT-1:0]};
    end

    always_comb begin
        hi_d = {1'b0, a_hi_q} + {1'b0, b_hi_q} + {{HI{1'b0}}, c1_q};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lo_q   <= '0;
            c1_q   <= 1'b0;
            a_hi_q <= '0;
            b_hi_q <= '0;
            v1_q   <= 1'b0;
        end else begin
            lo_q   <= lo_d[SPLIT-1:0];
            c1_q   <= lo_d[SPLIT];
            a_hi_q <= A[WIDTH-1:SPLIT];
            b_hi_q <= B[WIDTH-1:SPLIT];
            v1_q   <= in_valid;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q   <= '0;
            carry_q <= 1'b0;
            v2_q    <= 1'b0;
        end else begin
            sum_q   <= {hi_d[HI-1:0], lo_q};
            carry_q <= hi_d[HI];
            v2_q    <= v1_q;
        end
    end

    assign sum       = sum_q;
    assign carry_out = carry_q;
    assign out_valid = v2_q;

endmodule

// File: tb/tb_adder_33.sv
// Directed-vector and streaming bench for the pipelined 33-bit-result adder.
// Expected results come from hand-computed tables and a 33-bit golden sum.
module tb_adder_33;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] A;
    logic [31:0] B;
    logic [31:0] sum;
    logic        carry_out;
    logic        out_valid;

    int n_chk;
    int n_fail;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [32:0] exp;
    } vec_t;

    vec_t        vecs[9];
    logic [31:0] ra[100];
    logic [31:0] rb[100];
    logic [32:0] gold[100];

    adder_33 #(.WIDTH(32), .SPLIT(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .A         (A),
        .B         (B),
        .sum       (sum),
        .carry_out (carry_out),
        .out_valid (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [32:0] got,
                       input logic [32:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    initial begin
        n_chk    = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        A        = '0;
        B        = '0;

        vecs[0] = '{32'd8589931, 32'd10, 33'd8589941};
        vecs[1] = '{32'd25, 32'd12, 33'd37};
        vecs[2] = '{32'd511, 32'd1, 33'd512};
        vecs[3] = '{32'h0000_FFFF, 32'h1, 33'h0_0001_0000};
        vecs[4] = '{32'hFFFF_FFFF, 32'h1, 33'h1_0000_0000};
        vecs[5] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 33'h1_FFFF_FFFE};
        vecs[6] = '{32'h8000_0000, 32'h8000_0000, 33'h1_0000_0000};
        vecs[7] = '{32'h1234_8000, 32'h0000_8000, 33'h0_1235_0000};
        vecs[8] = '{32'h0, 32'h0, 33'h0};

        // Reset state, held across a clock edge
        @(posedge clk);
        #1;
        chk("reset_result", {carry_out, sum}, 33'h0);
        chk("reset_valid", {32'h0, out_valid}, 33'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("idle_valid", {32'h0, out_valid}, 33'h0);

        // Directed vectors, one at a time, latency checked
        foreach (vecs[i]) begin
            @(negedge clk);
            in_valid = 1'b1;
            A = vecs[i].a;
            B = vecs[i].b;
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d_lat1", i), {32'h0, out_valid}, 33'h0);
            @(negedge clk);
            in_valid = 1'b0;
            A = 32'hDEAD_BEEF;
            B = 32'hFFFF_FFFF;
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d_valid", i), {32'h0, out_valid}, 33'h1);
            chk($sformatf("vec%0d_result", i), {carry_out, sum}, vecs[i].exp);
        end

        // Low-half carry must not leak into the following slot
        @(negedge clk);
        in_valid = 1'b1;
        A = 32'h0000_FFFF;
        B = 32'h0000_0001;
        @(negedge clk);
        A = 32'h0;
        B = 32'h0;
        @(negedge clk);
        in_valid = 1'b0;
        chk("b2b_first", {carry_out, sum}, 33'h0_0001_0000);
        chk("b2b_first_v", {32'h0, out_valid}, 33'h1);
        @(negedge clk);
        chk("b2b_second", {carry_out, sum}, 33'h0);
        chk("b2b_second_v", {32'h0, out_valid}, 33'h1);

        // Streaming: 100 random pairs on consecutive cycles
        for (int i = 0; i < 100; i++) begin
            ra[i]   = $urandom;
            rb[i]   = $urandom;
            gold[i] = {1'b0, ra[i]} + {1'b0, rb[i]};
        end
        for (int c = 0; c < 102; c++) begin
            @(negedge clk);
            if (c < 100) begin
                in_valid = 1'b1;
                A = ra[c];
                B = rb[c];
            end else begin
                in_valid = 1'b0;
            end
            @(posedge clk);
            #1;
            if (c >= 1 && c <= 100) begin
                chk($sformatf("stream%0d_v", c - 1), {32'h0, out_valid}, 33'h1);
                chk($sformatf("stream%0d", c - 1), {carry_out, sum}, gold[c - 1]);
            end
        end
        chk("stream_drain_v", {32'h0, out_valid}, 33'h0);

        // Reset with two operations in flight
        @(negedge clk);
        in_valid = 1'b1;
        A = 32'h1111_1111;
        B = 32'h2222_2222;
        @(negedge clk);
        A = 32'hFFFF_FFFF;
        B = 32'h0000_0002;
        @(posedge clk);
        #1;
        chk("inflight_v", {32'h0, out_valid}, 33'h1);
        in_valid = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        chk("rst_async_result", {carry_out, sum}, 33'h0);
        chk("rst_async_v", {32'h0, out_valid}, 33'h0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            chk($sformatf("post_rst_idle%0d", k), {32'h0, out_valid}, 33'h0);
        end
        @(negedge clk);
        in_valid = 1'b1;
        A = 32'h0001_FFFF;
        B = 32'h0000_0001;
        @(posedge clk);
        #1;
        chk("post_rst_lat1", {32'h0, out_valid}, 33'h0);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("post_rst_v", {32'h0, out_valid}, 33'h1);
        chk("post_rst_result", {carry_out, sum}, 33'h0_0002_0000);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
